// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with branch/exception redirect and a one-entry pending branch.
// Defining PC_ALIGN_CHECK_EN turns on misaligned-fetch fault detection.
module pc_gen #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'hBFC0_0000),
   parameter int unsigned           INST_BYTES   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  pc_ready,
   input  logic                  br_valid,
   input  logic [ADDR_WIDTH-1:0] br_target,
   input  logic                  exc_valid,
   input  logic [ADDR_WIDTH-1:0] exc_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  ce,
   output logic                  pc_misalign
);

   localparam logic [ADDR_WIDTH-1:0] Inc = ADDR_WIDTH'(INST_BYTES);

   typedef enum logic [0:0] {StHold, StRun} state_e;

   state_e                  state_q;
   logic                    pend_valid_q;
   logic [ADDR_WIDTH-1:0]   pend_target_q;
   logic                    accept;
   logic                    capture;
   logic                    load;
   logic                    load_misalign;
   logic [ADDR_WIDTH-1:0]   load_pc;

   // ce is only ever high in StRun, so accept/capture need no extra state qualification.
   assign accept  = ce & pc_ready & ~stall;
   assign capture = ce & br_valid & ~accept & ~exc_valid;

   always_comb begin
      load    = 1'b0;
      load_pc = pc;
      if (exc_valid) begin
         load    = 1'b1;
         load_pc = exc_target;
      end else if (accept) begin
         load = 1'b1;
         if (br_valid) begin
            load_pc = br_target;
         end else if (pend_valid_q) begin
            load_pc = pend_target_q;
         end else begin
            load_pc = pc + Inc;
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   assign load_misalign = (load_pc % Inc) != '0;
`else
   assign load_misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StHold;
         pc            <= RESET_VECTOR;
         ce            <= 1'b0;
         pc_misalign   <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         case (state_q)
            StHold: begin
               // Branches are ignored here; only an exception can redirect.
               state_q      <= StRun;
               pend_valid_q <= 1'b0;
               if (load) begin
                  pc          <= load_pc;
                  ce          <= ~load_misalign;
                  pc_misalign <= load_misalign;
               end else begin
                  ce <= 1'b1;
               end
            end
            StRun: begin
               if (load) begin
                  pc           <= load_pc;
                  ce           <= ~load_misalign;
                  pc_misalign  <= load_misalign;
                  pend_valid_q <= 1'b0;
               end else if (capture) begin
                  pend_valid_q  <= 1'b1;
                  pend_target_q <= br_target;
               end
            end
            default: state_q <= StHold;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; each scenario drives a step table and checks
// the registered outputs one cycle later against constant expected values.
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        pc_ready;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_valid;
   logic [31:0] exc_target;
   logic [31:0] pc;
   logic        ce;
   logic        pc_misalign;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        rst, rdy, stl, br;
      logic [31:0] brt;
      logic        exc;
      logic [31:0] ext;
      logic [31:0] epc;
      logic        ece, emis;
      string       nm;
   } step_t;

   typedef struct {
      logic [31:0] pc;
      logic        ce, mis;
      string       nm;
   } exp_t;

   exp_t sb[$];

   pc_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .pc_ready    (pc_ready),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .exc_valid   (exc_valid),
      .exc_target  (exc_target),
      .pc          (pc),
      .ce          (ce),
      .pc_misalign (pc_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   function automatic step_t mk(logic rst, logic rdy, logic stl, logic br, logic [31:0] brt,
                                logic exc, logic [31:0] ext, logic [31:0] epc, logic ece,
                                logic emis, string nm);
      step_t s;
      s.rst = rst; s.rdy = rdy; s.stl = stl; s.br = br; s.brt = brt;
      s.exc = exc; s.ext = ext; s.epc = epc; s.ece = ece; s.emis = emis; s.nm = nm;
      return s;
   endfunction

   task automatic drive(input step_t s);
      rst_n      = s.rst;
      pc_ready   = s.rdy;
      stall      = s.stl;
      br_valid   = s.br;
      br_target  = s.brt;
      exc_valid  = s.exc;
      exc_target = s.ext;
   endtask

   task automatic push(input step_t s);
      exp_t e;
      e.pc = s.epc; e.ce = s.ece; e.mis = s.emis; e.nm = s.nm;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t st[$];
      exp_t  e;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ""));
      tick();
      tick();
      e.pc = 32'hBFC0_0000; e.ce = 1'b0; e.mis = 1'b0; e.nm = "reset_state";
      sb.push_back(e);
      e = sb.pop_front();
      n_cmp++;
      if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
         n_err++;
         $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                  e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
      end
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1, 0, "release_first"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1, 0, "seq_1"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1, 0, "seq_2"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   task automatic test_pending();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1, 0, 0, 1, 32'h8000_0100, 0, 0, 32'hBFC0_0008, 1, 0, "pend_cap"));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1, 0, "pend_hold1"));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1, 0, "pend_hold2"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h8000_0100, 1, 0, "pend_take"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h8000_0104, 1, 0, "pend_seq"));
      st.push_back(mk(1, 0, 0, 1, 32'h0000_1100, 0, 0, 32'h8000_0104, 1, 0, "ovw_first"));
      st.push_back(mk(1, 0, 0, 1, 32'h0000_1200, 0, 0, 32'h8000_0104, 1, 0, "ovw_second"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_1200, 1, 0, "ovw_take"));
      st.push_back(mk(1, 1, 0, 1, 32'h0000_1300, 0, 0, 32'h0000_1300, 1, 0, "br_accept"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_1304, 1, 0, "br_seq"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   task automatic test_priority();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1, 0, 0, 1, 32'h0000_1000, 1, 32'hBFC0_0380, 32'hBFC0_0380, 1, 0,
                      "exc_over_br"));
      st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0380, 1, 0, "exc_hold"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0384, 1, 0, "exc_no_pend"));
      st.push_back(mk(1, 1, 0, 1, 32'h0000_1000, 1, 32'h0000_7000, 32'h0000_7000, 1, 0,
                      "exc_over_br_acc"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_7004, 1, 0, "exc_seq"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   task automatic test_wrap();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, "wrap_load"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, "wrap_zero"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_0004, 1, 0, "wrap_seq"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   task automatic test_stall();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1, 1, 1, 1, 32'h0000_3000, 0, 0, 32'h0000_0004, 1, 0, "stall_cap"));
      st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h0000_0004, 1, 0, "stall_hold"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_3000, 1, 0, "stall_pend_take"));
      st.push_back(mk(1, 1, 1, 0, 0, 1, 32'h0000_6000, 32'h0000_6000, 1, 0, "stall_exc"));
      st.push_back(mk(1, 1, 1, 1, 32'h0000_8000, 0, 0, 32'h0000_6000, 1, 0, "stall_cap2"));
      st.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h0000_6000, 1, 0, "stall_hold2"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
      // Asynchronous reset mid-stall with a branch pending.
      #2;
      rst_n = 1'b0;
      e.pc = 32'hBFC0_0000; e.ce = 1'b0; e.mis = 1'b0; e.nm = "async_reset";
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
         n_err++;
         $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                  e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
      end
   endtask

   task automatic test_hold();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1, 1, 0, 1, 32'h0000_5000, 0, 0, 32'hBFC0_0000, 1, 0, "hold_br_ign"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1, 0, "hold_no_pend"));
      st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 0, "hold_rst_again"));
      st.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0000_4000, 32'h0000_4000, 1, 0, "hold_exc"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_4004, 1, 0, "hold_exc_seq"));
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   task automatic test_misalign();
      step_t st[$];
      exp_t  e;
`ifdef PC_ALIGN_CHECK_EN
      st.push_back(mk(1, 1, 0, 1, 32'h8000_0102, 0, 0, 32'h8000_0102, 0, 1, "mis_br"));
      st.push_back(mk(1, 1, 0, 1, 32'h0000_9000, 0, 0, 32'h8000_0102, 0, 1, "mis_stuck"));
      st.push_back(mk(1, 1, 0, 0, 0, 1, 32'hBFC0_0380, 32'hBFC0_0380, 1, 0, "mis_clear"));
      st.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0000_0006, 32'h0000_0006, 0, 1, "mis_exc"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_0006, 0, 1, "mis_exc_stuck"));
      st.push_back(mk(1, 0, 0, 0, 0, 1, 32'hBFC0_0380, 32'hBFC0_0380, 1, 0, "mis_clear2"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'hBFC0_0384, 1, 0, "mis_seq"));
`else
      st.push_back(mk(1, 1, 0, 1, 32'h8000_0102, 0, 0, 32'h8000_0102, 1, 0, "unchk_br"));
      st.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0000_0006, 32'h0000_0006, 1, 0, "unchk_exc"));
      st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 32'h0000_000A, 1, 0, "unchk_seq"));
`endif
      foreach (st[i]) begin
         drive(st[i]);
         push(st[i]);
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({pc, ce, pc_misalign} !== {e.pc, e.ce, e.mis}) begin
            n_err++;
            $display("FAIL %s: got pc=%h ce=%b mis=%b, want pc=%h ce=%b mis=%b",
                     e.nm, pc, ce, pc_misalign, e.pc, e.ce, e.mis);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pending();
      test_priority();
      test_wrap();
      test_stall();
      test_hold();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of pc and all target buses.
REQ-002 Parameter RESET_VECTOR, default 32'hBFC0_0000: pc value held during and after reset.
REQ-003 Parameter INST_BYTES, default 4: sequential increment per accepted fetch.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 stall  input  1  pipeline hold; blocks acceptance of the current fetch.
REQ-007 pc_ready  input  1  fetch side accepts current pc when high with ce high.
REQ-008 br_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-009 br_target  input  ADDR_WIDTH  branch destination.
REQ-010 exc_valid  input  1  exception/flush redirect, single-cycle pulse.
REQ-011 exc_target  input  ADDR_WIDTH  exception handler address.
REQ-012 pc  output  ADDR_WIDTH  current fetch address, registered.
REQ-013 ce  output  1  fetch request valid, registered.
REQ-014 pc_misalign  output  1  fetch address alignment fault, registered.

Function
REQ-015 States: HOLD (ce=0) and RUN (ce=1 unless faulted); HOLD -> RUN on first rising edge after rst_n release.
REQ-016 Accept = ce & pc_ready & ~stall; pc SHALL change only on accept or exc_valid.
REQ-017 While ce=1 and no accept: pc and ce SHALL hold stable (request stability rule).
REQ-018 Accept, no redirect, no pending: next pc = pc + INST_BYTES, modulo 2^ADDR_WIDTH (wraps all-ones region to 0).
REQ-019 Priority per cycle: exc_valid > br_valid > pending branch > sequential.
REQ-020 exc_valid (any state incl. HOLD, any handshake): next pc = exc_target, pending cleared, ce=1, state RUN; current request abandoned.
REQ-021 br_valid with accept same cycle: next pc = br_target, pending cleared.
REQ-022 br_valid without accept (ce=1): br_target stored in pending register, pc held.
REQ-023 br_valid while pending valid: newer target overwrites pending.
REQ-024 Accept with pending valid and no new redirect: next pc = pending target, pending cleared.
REQ-025 br_valid in HOLD: ignored.
REQ-026 Redirect latency: exactly one clock from qualifying edge to new pc on output.
REQ-027 stall=1 SHALL not block exc_valid or pending capture.

Reset
REQ-028 rst_n low: pc=RESET_VECTOR, ce=0, pc_misalign=0, pending cleared, state HOLD, immediately (async).
REQ-029 Reset mid-request or with pending branch: all discarded, no partial state survives.
REQ-030 First rising edge with rst_n high: ce=1, pc=RESET_VECTOR unchanged.

Configuration
REQ-031 Macro PC_ALIGN_CHECK_EN.
REQ-032 Defined: any loaded pc with pc mod INST_BYTES != 0 sets pc_misalign=1 and ce=0 from that cycle; pc holds faulting address; only exc_valid or reset clears (pc_misalign=0 when a new aligned pc is loaded).
REQ-033 Defined, exc_target itself misaligned: fault re-raised per REQ-032.
REQ-034 Not defined: pc_misalign tied 0, targets loaded unchecked, no ce suppression.

Verification
REQ-035 Release rst_n, pc_ready=1: cycle1 ce=1 pc=BFC00000; then BFC00004, BFC00008 each cycle.
REQ-036 pc_ready=0 three cycles with br_valid pulse target 80000100 in first: pc held; on pc_ready=1 next pc=80000100.
REQ-037 Same cycle br_valid (00001000) and exc_valid (BFC00380), pc_ready=0: next pc=BFC00380, pending empty (later accept gives BFC00384).
REQ-038 ADDR_WIDTH=32, pc=FFFFFFFC, accept: next pc=00000000.
REQ-039 stall=1, pc_ready=1 two cycles: pc unchanged; assert rst_n low mid-stall: pc=BFC00000, ce=0 same cycle.
REQ-040 PC_ALIGN_CHECK_EN defined, br_target 80000102 accepted: pc=80000102, pc_misalign=1, ce=0; exc_valid BFC00380 -> pc_misalign=0, ce=1.
